// File: rtl/neuron_integrator.sv
// rtl/neuron_integrator.sv - saturating spike accumulator with leak, emit and feedback handshake
module neuron_integrator (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spike_valid,
   input  logic [1:0]  spike_axon_type,
   output logic        spike_ready,
   input  logic [31:0] weights,
   input  logic [7:0]  leak,
   input  logic        tick,
   output logic [7:0]  membrane_potential,
   output logic        mp_valid,
   output logic [7:0]  spike_count,
   input  logic        fb_valid,
   input  logic [7:0]  fb_potential,
   output logic        busy,
   output logic        tick_overrun
);

   typedef enum logic [1:0] {S_ACCUM, S_LEAK, S_EMIT, S_WAIT_FB} state_t;

   state_t      state_q, state_d;
   logic [7:0]  acc_q, acc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ovr_q, ovr_d;
   logic [7:0]  w_sel;

   // Unsigned accumulator plus signed operand in 10 bits, clamped to [0,255].
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [9:0] sum;
      sum = {2'b00, a} + {{2{b[7]}}, b};
      if (sum[9])
         return 8'd0;
      else if (sum[8])
         return 8'hFF;
      else
         return sum[7:0];
   endfunction

   always_comb begin
      w_sel = weights[7:0];
      case (spike_axon_type)
         2'd0: w_sel = weights[7:0];
         2'd1: w_sel = weights[15:8];
         2'd2: w_sel = weights[23:16];
         2'd3: w_sel = weights[31:24];
         default: w_sel = weights[7:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ACCUM;
         acc_q   <= 8'd0;
         cnt_q   <= 8'd0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACCUM:   if (tick) state_d = S_LEAK;
         S_LEAK:    state_d = S_EMIT;
         S_EMIT:    state_d = S_WAIT_FB;
         S_WAIT_FB: if (fb_valid) state_d = S_ACCUM;
         default:   state_d = S_ACCUM;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovr_d = ovr_q | (tick && (state_q != S_ACCUM));
      case (state_q)
         S_ACCUM: begin
            if (spike_valid) begin
               acc_d = sat_add(acc_q, w_sel);
               cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
         end
         S_LEAK: acc_d = sat_add(acc_q, leak);
         S_WAIT_FB: begin
            if (fb_valid) begin
               acc_d = fb_potential;
               cnt_d = 8'd0;
            end
         end
         default: ;
      endcase
   end

   // All outputs are pure decodes of registers: no input-to-output paths.
   always_comb begin
      spike_ready        = (state_q == S_ACCUM);
      busy               = (state_q != S_ACCUM);
      mp_valid           = (state_q == S_EMIT);
      membrane_potential = acc_q;
      spike_count        = cnt_q;
      tick_overrun       = ovr_q;
   end

endmodule

// File: tb/tb_neuron_integrator.sv
// tb/tb_neuron_integrator.sv - directed bench for neuron_integrator
module tb_neuron_integrator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spike_valid = 1'b0;
   logic [1:0]  spike_axon_type = 2'd0;
   logic        spike_ready;
   logic [31:0] weights = 32'd0;
   logic [7:0]  leak = 8'd0;
   logic        tick = 1'b0;
   logic [7:0]  membrane_potential;
   logic        mp_valid;
   logic [7:0]  spike_count;
   logic        fb_valid = 1'b0;
   logic [7:0]  fb_potential = 8'd0;
   logic        busy;
   logic        tick_overrun;

   int total = 0;
   int bad = 0;

   neuron_integrator dut (
      .clk(clk),
      .rst_n(rst_n),
      .spike_valid(spike_valid),
      .spike_axon_type(spike_axon_type),
      .spike_ready(spike_ready),
      .weights(weights),
      .leak(leak),
      .tick(tick),
      .membrane_potential(membrane_potential),
      .mp_valid(mp_valid),
      .spike_count(spike_count),
      .fb_valid(fb_valid),
      .fb_potential(fb_potential),
      .busy(busy),
      .tick_overrun(tick_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Walk ACCUM -> LEAK -> EMIT -> WAIT_FB and return with acc = v, count = 0.
   task automatic load_acc(input logic [7:0] v);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      cyc();
      fb_valid = 1'b1;
      fb_potential = v;
      cyc();
      fb_valid = 1'b0;
   endtask

   initial begin
      weights = {8'h80, 8'd100, 8'hFB, 8'd10};
      leak = 8'hFF;
      #12;
      chk("rst_ready", spike_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mpv", mp_valid, 0);
      chk("rst_mp", membrane_potential, 0);
      chk("rst_cnt", spike_count, 0);
      chk("rst_ovr", tick_overrun, 0);
      rst_n = 1'b1;
      cyc();

      // Spikes 0,0,1 then tick with leak -1 -> 14, count 3
      spike_valid = 1'b1;
      spike_axon_type = 2'd0;
      cyc();
      cyc();
      spike_axon_type = 2'd1;
      cyc();
      chk("acc_15", membrane_potential, 15);
      spike_valid = 1'b0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("leak_mpv", mp_valid, 0);
      chk("leak_busy", busy, 1);
      chk("leak_ready", spike_ready, 0);
      cyc();
      chk("emit_mpv", mp_valid, 1);
      chk("emit_mp", membrane_potential, 14);
      chk("emit_cnt", spike_count, 3);
      cyc();
      chk("wait_mpv", mp_valid, 0);
      chk("wait_busy", busy, 1);

      // Tick in WAIT_FB: overrun, no state change, no second emit
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("ovr_set", tick_overrun, 1);
      chk("ovr_busy", busy, 1);
      cyc();
      chk("ovr_mpv", mp_valid, 0);
      chk("ovr_ready", spike_ready, 0);
      fb_valid = 1'b1;
      fb_potential = 8'h40;
      cyc();
      fb_valid = 1'b0;
      chk("fb_ready", spike_ready, 1);
      chk("fb_acc", membrane_potential, 8'h40);
      chk("fb_cnt", spike_count, 0);
      chk("fb_ovr_sticky", tick_overrun, 1);

      // fb_valid in ACCUM is ignored
      fb_valid = 1'b1;
      fb_potential = 8'h77;
      cyc();
      fb_valid = 1'b0;
      chk("fb_ign_acc", membrane_potential, 8'h40);
      chk("fb_ign_ready", spike_ready, 1);

      // Upper clamp
      load_acc(8'd200);
      chk("load200", membrane_potential, 200);
      spike_valid = 1'b1;
      spike_axon_type = 2'd2;
      cyc();
      cyc();
      cyc();
      spike_valid = 1'b0;
      chk("clamp_hi", membrane_potential, 255);
      leak = 8'd5;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk("clamp_emit_mpv", mp_valid, 1);
      chk("clamp_emit_mp", membrane_potential, 255);
      chk("clamp_emit_cnt", spike_count, 3);
      cyc();
      fb_valid = 1'b1;
      fb_potential = 8'd3;
      cyc();
      fb_valid = 1'b0;

      // Lower clamp
      spike_valid = 1'b1;
      spike_axon_type = 2'd3;
      cyc();
      spike_valid = 1'b0;
      chk("clamp_lo", membrane_potential, 0);

      // Spike and tick in the same cycle
      load_acc(8'd0);
      leak = 8'd0;
      spike_valid = 1'b1;
      spike_axon_type = 2'd0;
      tick = 1'b1;
      cyc();
      spike_valid = 1'b0;
      tick = 1'b0;
      chk("same_busy", busy, 1);
      cyc();
      chk("same_mpv", mp_valid, 1);
      chk("same_mp", membrane_potential, 10);
      chk("same_cnt", spike_count, 1);
      cyc();
      fb_valid = 1'b1;
      fb_potential = 8'd7;
      cyc();
      fb_valid = 1'b0;

      // Count saturation with zero weight
      weights[7:0] = 8'd0;
      spike_valid = 1'b1;
      spike_axon_type = 2'd0;
      for (int i = 0; i < 100; i++) cyc();
      chk("cnt_100", spike_count, 100);
      for (int i = 0; i < 200; i++) cyc();
      spike_valid = 1'b0;
      chk("cnt_sat", spike_count, 255);
      chk("cnt_acc", membrane_potential, 7);

      // Reset during EMIT
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk("pre_rst_mpv", mp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_mpv", mp_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_mp", membrane_potential, 0);
      chk("arst_cnt", spike_count, 0);
      chk("arst_ovr", tick_overrun, 0);
      #10;
      rst_n = 1'b1;
      cyc();
      chk("post_rst_ready", spike_ready, 1);
      chk("post_rst_mpv", mp_valid, 0);
      cyc();
      chk("post_rst_mpv2", mp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_integrator.md
NEURON_INTEGRATOR -- requirements
Module: neuron_integrator

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first:
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 spike_valid  input  1  incoming spike event present.
REQ-005 spike_axon_type  input  2  axon type of the spike; selects the weight.
REQ-006 spike_ready  output  1  block accepts a spike this cycle.
REQ-007 weights  input  32  four signed 8-bit weights; type k at bits [8k+7:8k].
REQ-008 leak  input  8  signed leak, added once per time step.
REQ-009 tick  input  1  one-cycle time-step boundary strobe.
REQ-010 membrane_potential  output  8  unsigned accumulator value, registered.
REQ-011 mp_valid  output  1  one-cycle strobe; membrane_potential is final for this step.
REQ-012 spike_count  output  8  spikes accepted in the current step, saturating.
REQ-013 fb_valid  input  1  post-threshold potential returned by the threshold stage.
REQ-014 fb_potential  input  8  returned potential (reset or pass-through value).
REQ-015 busy  output  1  high in any state other than ACCUM.
REQ-016 tick_overrun  output  1  sticky; a tick arrived outside ACCUM.

Function
REQ-017 SHALL implement FSM states ACCUM, LEAK, EMIT, WAIT_FB.
REQ-018 ACCUM:
- spike_ready=1.
- On spike_valid&spike_ready: acc <= sat(acc + weights[type]) and spike_count <= min(spike_count+1, 255).
REQ-019 ACCUM with tick=1 SHALL go to LEAK next cycle; a spike accepted in the same cycle as tick counts toward this step.
REQ-020 LEAK SHALL be one cycle with spike_ready=0: acc <= sat(acc + leak); then go to EMIT.
REQ-021 EMIT SHALL be one cycle:
- mp_valid=1, membrane_potential = post-leak acc, spike_count holds the step total.
- Then go to WAIT_FB.
REQ-022 WAIT_FB SHALL keep spike_ready=0 and wait indefinitely; on fb_valid:
- acc <= fb_potential, spike_count <= 0.
- Go to ACCUM.
REQ-023 Latency: tick accepted in cycle N gives mp_valid in cycle N+2; fb_valid in cycle M gives spike_ready=1 in cycle M+1.
REQ-024 Arithmetic:
- Sum formed in 10-bit signed from zero-extended acc and sign-extended operand.
- Result <0 clamps to 0; result >255 clamps to 255.
- No wrap-around under any input.
REQ-025 tick in LEAK, EMIT or WAIT_FB SHALL be ignored (no state change) and set tick_overrun; it is cleared only by reset.
REQ-026 fb_valid outside WAIT_FB SHALL be ignored.
REQ-027 spike_valid while spike_ready=0 SHALL not be accepted; the sender holds the spike.
REQ-028 mp_valid SHALL never be high for two consecutive cycles.
REQ-029 busy SHALL be a decode of the registered state; no combinational input-to-output paths except none (spike_ready also decoded from state).

Reset
REQ-030 On rst_n=0, asynchronously:
- State=ACCUM, acc=0, spike_count=0.
- mp_valid=0, tick_overrun=0, busy=0, spike_ready=1 after release.
REQ-031 Reset asserted mid-step (any state) SHALL discard the partial step; no mp_valid is produced for it.

Verification
REQ-032 Weights {w0=+10,w1=-5,w2=+100,w3=-128}, leak=-1: spikes types 0,0,1, then tick -> mp_valid two cycles after tick with potential 14, spike_count 3.
REQ-033 From acc=200: three type-2 spikes -> acc 255 (clamped); leak=+5, tick -> potential 255. From acc=3: type-3 spike -> 0.
REQ-034 Spike and tick in the same cycle with acc=0, w0=+10, leak=0 -> potential 10, spike_count 1.
REQ-035 tick during WAIT_FB -> tick_overrun=1, no second mp_valid. Then fb_valid with fb_potential=0x40 -> next cycle spike_ready=1, acc=0x40, spike_count=0.
REQ-036 300 type-0 spikes with w0=0 -> spike_count saturates at 255.
REQ-037 rst_n low during EMIT -> mp_valid falls immediately, all outputs at reset values, spike_ready=1 after release.
